// File: rtl/polar_pkg.sv
// Shared polar-chain definitions used by the encoder-side inserter and the decode-side extractor.
package polar_pkg;

  typedef enum logic {FILL, HOLD} ins_state_t;

  function automatic int index_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/frozen_insert.sv
// Places K serial info bits onto the most reliable of N channels and holds the
// assembled u-vector until the consumer takes it; all other positions stay 0.
module frozen_insert
  import polar_pkg::*;
#(
  parameter int N  = 32,
  parameter int K  = 16,
  parameter int IW = index_width(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0][IW-1:0]   sorted_indexes,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_bit,
  input  logic                   in_last,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [N-1:0]           frame,
  output logic                   len_err
);

  localparam int CW = $clog2(K + 1);
  localparam int SW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  ins_state_t     r_state;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_frame;
  logic           r_len_err;

  logic           w_accept;
  logic [SW-1:0]  w_slot;
  logic [SW-1:0]  w_pos;

  assign in_ready    = (r_state == FILL);
  assign frame_valid = (r_state == HOLD);
  assign frame       = r_frame;
  assign len_err     = r_len_err;
  assign w_accept    = in_valid && in_ready;

  // Bit i goes to the i-th most reliable channel, i.e. counting down from the table end.
  // The top bit of a table entry is unused for a valid permutation of 0..N-1.
  always_comb begin
    w_slot = SW'(N - 1 - int'(r_cnt));
    w_pos  = sorted_indexes[w_slot][SW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FILL;
      r_cnt     <= '0;
      r_frame   <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_cnt == LAST) begin
              // A missing in_last still completes the frame but is flagged.
              r_frame[w_pos] <= in_bit;
              r_cnt          <= r_cnt + 1'b1;
              r_state        <= HOLD;
              r_len_err      <= !in_last;
            end else if (in_last) begin
              r_frame   <= '0;
              r_cnt     <= '0;
              r_len_err <= 1'b1;
            end else begin
              r_frame[w_pos] <= in_bit;
              r_cnt          <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (frame_ready) begin
            r_state <= FILL;
            r_frame <= '0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule
